// File: rtl/dlx_mem_arbiter_if.sv
// dlx_mem_arbiter_if: bundles the fetch port, the load/store port, the memory
// port and the status lines of the DLX memory arbiter.
//   fetch : if_req, if_addr -> if_ack, if_rdata
//   data  : d_req, d_we, d_word, d_signed, d_addr, d_wdata -> d_ack, d_rdata
//   memory: mem_valid, mem_we, mem_be, mem_addr, mem_wdata <- mem_ready, mem_rdata
//   status: stall, err
// modport master is the arbiter's view; modport slave is the view of the
// surrounding pipeline and memory.
interface dlx_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic        d_word;
  logic        d_signed;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;

  logic        mem_valid;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        stall;
  logic        err;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_word, d_signed, d_addr, d_wdata,
           mem_ready, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata,
           mem_valid, mem_we, mem_be, mem_addr, mem_wdata, stall, err
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_word, d_signed, d_addr, d_wdata,
           mem_ready, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata,
           mem_valid, mem_we, mem_be, mem_addr, mem_wdata, stall, err
  );
endinterface

// File: rtl/dlx_mem_arbiter.sv
// dlx_mem_arbiter: shares the single-ported DLX memory between instruction
// fetch and load/store. One requester is granted at a time; the memory
// transaction is registered, byte lanes are big-endian (mem_be[3] = offset 0),
// byte loads are sign- or zero-extended, and each requester gets a one-cycle
// ack with registered read data.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high
//   bus    - dlx_mem_arbiter_if.master (fetch, data, memory, stall, err)
// Parameters:
//   STARVE_LIMIT   - data grants in a row allowed while fetch waits (1..15)
//   TIMEOUT_CYCLES - memory wait cycles before abort (timeout build only)
// Optional feature: define DLX_MEM_ARB_TIMEOUT_EN to abort a memory wait
// after TIMEOUT_CYCLES cycles with ack + err; otherwise err is tied low.
module dlx_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  dlx_mem_arbiter_if.master bus
);

  localparam int unsigned       CNT_W   = 4;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  LIMIT   = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, FETCH, DATA, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  // Attributes of the granted data access, kept for the response
  logic             byte_load;
  logic             load_signed;
  logic             is_store;
  logic [1:0]       byte_off;

  logic             grant_d_c;
  logic             grant_f_c;
  logic [3:0]       byte_be_c;
  logic [31:0]      store_data_c;
  logic [7:0]       lane_c;
  logic [31:0]      load_data_c;

  // Data wins unless fetch has already been passed over STARVE_LIMIT times
  assign grant_d_c    = bus.d_req && (!bus.if_req || (starve_cnt < LIMIT));
  assign grant_f_c    = bus.if_req && !grant_d_c;
  assign byte_be_c    = 4'b1000 >> bus.d_addr[1:0];
  assign store_data_c = bus.d_word ? bus.d_wdata : {4{bus.d_wdata[7:0]}};

  assign bus.stall = (bus.if_req & ~bus.if_ack) | (bus.d_req & ~bus.d_ack);

  // Big-endian lane select and extension of the returned word
  always_comb begin
    lane_c      = '0;
    load_data_c = bus.mem_rdata;
    case (byte_off)
      2'd0:    lane_c = bus.mem_rdata[31:24];
      2'd1:    lane_c = bus.mem_rdata[23:16];
      2'd2:    lane_c = bus.mem_rdata[15:8];
      default: lane_c = bus.mem_rdata[7:0];
    endcase
    if (byte_load) begin
      load_data_c = load_signed ? {{24{lane_c[7]}}, lane_c} : {24'h0, lane_c};
    end
  end

`ifdef DLX_MEM_ARB_TIMEOUT_EN
  localparam int unsigned      TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] wait_cnt;
  logic            err_q;
  logic            timeout_c;

  // Last permitted wait cycle: abort instead of waiting further
  assign timeout_c = (wait_cnt == TO_LAST);
  assign bus.err   = err_q;
`else
  // No abort path: err can never fire
  assign bus.err = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  // Arbitration FSM with registered memory transaction and responses
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      byte_load     <= 1'b0;
      load_signed   <= 1'b0;
      is_store      <= 1'b0;
      byte_off      <= 2'd0;
      bus.mem_valid <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= 4'h0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.if_ack    <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_ack     <= 1'b0;
      bus.d_rdata   <= '0;
`ifdef DLX_MEM_ARB_TIMEOUT_EN
      wait_cnt      <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      bus.if_ack <= 1'b0;
      bus.d_ack  <= 1'b0;
`ifdef DLX_MEM_ARB_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef DLX_MEM_ARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          if (grant_d_c) begin
            state         <= DATA;
            bus.mem_valid <= 1'b1;
            bus.mem_we    <= bus.d_we;
            bus.mem_be    <= bus.d_word ? 4'hF : byte_be_c;
            bus.mem_addr  <= {bus.d_addr[31:2], 2'b00};
            bus.mem_wdata <= store_data_c;
            byte_load     <= !bus.d_word;
            load_signed   <= bus.d_signed;
            is_store      <= bus.d_we;
            byte_off      <= bus.d_addr[1:0];
            if (!bus.if_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != CNT_MAX) begin
              starve_cnt <= starve_cnt + CNT_W'(1);
            end
          end else if (grant_f_c) begin
            state         <= FETCH;
            bus.mem_valid <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= 4'hF;
            bus.mem_addr  <= bus.if_addr & 32'hFFFF_FFFC;
            bus.mem_wdata <= '0;
            starve_cnt    <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end

        FETCH, DATA: begin
          if (bus.mem_ready) begin
            state         <= RESP;
            bus.mem_valid <= 1'b0;
            bus.mem_we    <= 1'b0;
            if (state == FETCH) begin
              bus.if_ack   <= 1'b1;
              bus.if_rdata <= bus.mem_rdata;
            end else begin
              bus.d_ack   <= 1'b1;
              bus.d_rdata <= is_store ? 32'h0 : load_data_c;
            end
          end
`ifdef DLX_MEM_ARB_TIMEOUT_EN
          else if (timeout_c) begin
            state         <= RESP;
            bus.mem_valid <= 1'b0;
            bus.mem_we    <= 1'b0;
            err_q         <= 1'b1;
            if (state == FETCH) begin
              bus.if_ack   <= 1'b1;
              bus.if_rdata <= '0;
            end else begin
              bus.d_ack   <= 1'b1;
              bus.d_rdata <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
`endif
        end

        // Ack is visible this cycle; requests are deliberately not sampled
        RESP: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dlx_mem_arbiter.sv
// tb_dlx_mem_arbiter: directed scenarios plus a randomized two-requester run
// against a word-array memory model and a shadow copy of expected contents.
module tb_dlx_mem_arbiter;

  localparam int unsigned SL = 4;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dlx_mem_arbiter_if bus ();

  dlx_mem_arbiter #(
    .STARVE_LIMIT   (SL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Memory side: manual values for directed tests, random-latency model otherwise
  logic        auto_mode  = 1'b0;
  logic        man_ready  = 1'b0;
  logic [31:0] man_rdata  = 32'h0;
  logic        auto_ready = 1'b0;
  logic [31:0] auto_rdata = 32'h0;
  int          wait_left  = 0;

  logic [31:0] tmem   [0:255];
  logic [31:0] shadow [0:255];

  assign bus.mem_ready = auto_mode ? auto_ready : man_ready;
  assign bus.mem_rdata = auto_mode ? auto_rdata : man_rdata;

  initial begin
    forever begin
      @(negedge clk);
      auto_ready = 1'b0;
      if (auto_mode && bus.mem_valid) begin
        if (wait_left == 0) begin
          logic [31:0] t;
          logic [7:0]  idx;
          idx        = bus.mem_addr[9:2];
          t          = tmem[idx];
          auto_rdata = t;
          if (bus.mem_we) begin
            for (int i = 0; i < 4; i++)
              if (bus.mem_be[3-i]) t[31-8*i -: 8] = bus.mem_wdata[31-8*i -: 8];
            tmem[idx] = t;
          end
          auto_ready = 1'b1;
          wait_left  = $urandom_range(0, 3);
        end else begin
          wait_left = wait_left - 1;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.if_req   = 1'b0;
    bus.if_addr  = 32'h0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_word   = 1'b0;
    bus.d_signed = 1'b0;
    bus.d_addr   = 32'h0;
    bus.d_wdata  = 32'h0;
    man_ready    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.mem_valid, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_mem: got v=%b we=%b be=%h a=%h wd=%h required all zero",
               bus.mem_valid, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if ({bus.if_ack, bus.d_ack, bus.if_rdata, bus.d_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_resp: got if_ack=%b d_ack=%b if_rdata=%h d_rdata=%h required all zero",
               bus.if_ack, bus.d_ack, bus.if_rdata, bus.d_rdata);
    end
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b required 0", bus.err);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got %b required 0", bus.stall);
    end
  endtask

  task automatic test_fetch_single();
    bus.if_addr = 32'h100;
    bus.if_req  = 1'b1;
    man_rdata   = 32'h2001_0005;
    man_ready   = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_be !== 4'hF || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL fetch_txn: got v=%b a=%h be=%h we=%b required 1 00000100 f 0",
               bus.mem_valid, bus.mem_addr, bus.mem_be, bus.mem_we);
    end
    checks++;
    if (bus.if_ack !== 1'b0 || bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL fetch_early: got if_ack=%b stall=%b required 0 1", bus.if_ack, bus.stall);
    end
    @(negedge clk);
    checks++;
    if (bus.if_ack !== 1'b1 || bus.if_rdata !== 32'h2001_0005) begin
      errors++;
      $display("FAIL fetch_ack: got ack=%b rdata=%h required 1 20010005", bus.if_ack, bus.if_rdata);
    end
    checks++;
    if (bus.stall !== 1'b0 || bus.d_ack !== 1'b0 || bus.mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_resp_state: got stall=%b d_ack=%b v=%b required 0 0 0",
               bus.stall, bus.d_ack, bus.mem_valid);
    end
    bus.if_req = 1'b0;
    man_ready  = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.if_ack !== 1'b0) begin
      errors++;
      $display("FAIL fetch_ack_pulse: got %b required 0", bus.if_ack);
    end
    @(negedge clk);
  endtask

  task automatic test_byte_access();
    // LB, LBU, SB, misaligned LW, SW
    logic [31:0] addr_t  [5] = '{32'h203, 32'h203, 32'h301, 32'h203, 32'h304};
    logic        we_t    [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        word_t  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        sgn_t   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] wd_t    [5] = '{32'h0, 32'h0, 32'h1234_5678, 32'h0, 32'hA5A5_1234};
    logic [31:0] mrd_t   [5] = '{32'h0000_00F0, 32'h0000_00F0, 32'hDEAD_BEEF, 32'h89AB_CDEF, 32'h5555_AAAA};
    logic [3:0]  be_t    [5] = '{4'b0001, 4'b0001, 4'b0100, 4'hF, 4'hF};
    logic [31:0] ma_t    [5] = '{32'h200, 32'h200, 32'h300, 32'h200, 32'h304};
    logic [31:0] mwd_t   [5] = '{32'h0, 32'h0, 32'h7878_7878, 32'h0, 32'hA5A5_1234};
    logic [31:0] rd_t    [5] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'h0, 32'h89AB_CDEF, 32'h0};
    for (int k = 0; k < 5; k++) begin
      bus.d_addr   = addr_t[k];
      bus.d_we     = we_t[k];
      bus.d_word   = word_t[k];
      bus.d_signed = sgn_t[k];
      bus.d_wdata  = wd_t[k];
      bus.d_req    = 1'b1;
      man_rdata    = mrd_t[k];
      man_ready    = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.mem_valid !== 1'b1 || bus.mem_addr !== ma_t[k] || bus.mem_be !== be_t[k] || bus.mem_we !== we_t[k]) begin
        errors++;
        $display("FAIL data_txn[%0d]: got v=%b a=%h be=%b we=%b required 1 %h %b %b",
                 k, bus.mem_valid, bus.mem_addr, bus.mem_be, bus.mem_we, ma_t[k], be_t[k], we_t[k]);
      end
      if (we_t[k]) begin
        checks++;
        if (bus.mem_wdata !== mwd_t[k]) begin
          errors++;
          $display("FAIL data_wdata[%0d]: got %h required %h", k, bus.mem_wdata, mwd_t[k]);
        end
      end
      @(negedge clk);
      checks++;
      if (bus.d_ack !== 1'b1 || bus.d_rdata !== rd_t[k] || bus.if_ack !== 1'b0) begin
        errors++;
        $display("FAIL data_ack[%0d]: got d_ack=%b rdata=%h if_ack=%b required 1 %h 0",
                 k, bus.d_ack, bus.d_rdata, bus.if_ack, rd_t[k]);
      end
      bus.d_req = 1'b0;
      man_ready = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_starvation();
    logic is_f [10];
    int   n_grants   = 0;
    logic prev_valid = 1'b0;
    logic exp_f;
    reset = 1'b1;
    @(negedge clk);
    reset        = 1'b0;
    bus.if_addr  = 32'h40;
    bus.d_addr   = 32'h240;
    bus.d_we     = 1'b0;
    bus.d_word   = 1'b1;
    man_rdata    = 32'h1;
    man_ready    = 1'b1;
    bus.if_req   = 1'b1;
    bus.d_req    = 1'b1;
    for (int c = 0; c < 80 && n_grants < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b1) begin
        errors++;
        $display("FAIL starve_stall cycle %0d: got %b required 1", c, bus.stall);
      end
      if (bus.mem_valid && !prev_valid) begin
        is_f[n_grants] = (bus.mem_addr == 32'h40);
        n_grants++;
      end
      prev_valid = bus.mem_valid;
    end
    checks++;
    if (n_grants != 10) begin
      errors++;
      $display("FAIL starve_count: got %0d grants required 10 within budget", n_grants);
    end
    for (int k = 0; k < n_grants; k++) begin
      exp_f = ((k % (SL + 1)) == SL);
      checks++;
      if (is_f[k] !== exp_f) begin
        errors++;
        $display("FAIL starve_order grant %0d: got %s required %s", k,
                 is_f[k] ? "F" : "D", exp_f ? "F" : "D");
      end
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    repeat (4) @(negedge clk);
    man_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic quiet = 1'b1;
    bus.d_addr = 32'h260;
    bus.d_we   = 1'b0;
    bus.d_word = 1'b1;
    bus.d_req  = 1'b1;
    man_ready  = 1'b0;
    man_rdata  = 32'h1357_9BDF;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_wait: got mem_valid=%b required 1", bus.mem_valid);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_valid !== 1'b0 || bus.d_ack !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_abort: got v=%b d_ack=%b required 0 0", bus.mem_valid, bus.d_ack);
    end
    reset     = 1'b0;
    bus.d_req = 1'b0;
    man_ready = 1'b1;
    @(negedge clk);
    man_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (bus.d_ack !== 1'b0 || bus.if_ack !== 1'b0 || bus.mem_valid !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_late_ready: got activity after reset required none");
    end
  endtask

  task automatic test_wait_limit();
`ifdef DLX_MEM_ARB_TIMEOUT_EN
    int valid_cycles = 0;
    bus.if_addr = 32'h80;
    bus.if_req  = 1'b1;
    man_ready   = 1'b0;
    man_rdata   = 32'hFFFF_FFFF;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!bus.mem_valid) break;
      valid_cycles++;
    end
    checks++;
    if (valid_cycles != TO) begin
      errors++;
      $display("FAIL timeout_len: got %0d wait cycles required %0d", valid_cycles, TO);
    end
    checks++;
    if (bus.if_ack !== 1'b1 || bus.err !== 1'b1 || bus.if_rdata !== 32'h0) begin
      errors++;
      $display("FAIL timeout_abort: got if_ack=%b err=%b rdata=%h required 1 1 0",
               bus.if_ack, bus.err, bus.if_rdata);
    end
    bus.if_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.err !== 1'b0 || bus.if_ack !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse: got err=%b if_ack=%b required 0 0", bus.err, bus.if_ack);
    end
`else
    logic held = 1'b1;
    bus.if_addr = 32'hC2;
    bus.if_req  = 1'b1;
    man_ready   = 1'b0;
    man_rdata   = 32'hCAFE_0001;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.mem_valid !== 1'b1 || bus.if_ack !== 1'b0 || bus.err !== 1'b0 ||
          bus.mem_addr !== 32'hC0) held = 1'b0;
    end
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL long_wait_hold: got transaction not held (v=%b a=%h err=%b) required held",
               bus.mem_valid, bus.mem_addr, bus.err);
    end
    man_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.if_ack !== 1'b1 || bus.if_rdata !== 32'hCAFE_0001 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL long_wait_ack: got ack=%b rdata=%h err=%b required 1 cafe0001 0",
               bus.if_ack, bus.if_rdata, bus.err);
    end
    bus.if_req = 1'b0;
    man_ready  = 1'b0;
    @(negedge clk);
`endif
    @(negedge clk);
  endtask

  task automatic test_random();
    int mism = 0;
    for (int i = 0; i < 256; i++) begin
      tmem[i]   = $urandom;
      shadow[i] = tmem[i];
    end
    wait_left = 0;
    auto_mode = 1'b1;
    fork
      begin : fetch_thread
        for (int n = 0; n < 40; n++) begin
          int   w;
          int   off;
          logic got;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          w           = $urandom_range(0, 127);
          off         = $urandom_range(0, 3);
          bus.if_addr = 32'(w * 4 + off);
          bus.if_req  = 1'b1;
          got         = 1'b0;
          for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.if_ack) begin
              got = 1'b1;
              break;
            end
          end
          checks++;
          if (!got) begin
            errors++;
            $display("FAIL rand_fetch_timeout n=%0d: got no if_ack required ack", n);
          end else if (bus.if_rdata !== shadow[w]) begin
            errors++;
            $display("FAIL rand_fetch n=%0d addr=%h: got %h required %h", n, bus.if_addr, bus.if_rdata, shadow[w]);
          end
          bus.if_req = 1'b0;
        end
      end
      begin : data_thread
        for (int n = 0; n < 60; n++) begin
          int          kind;
          int          w;
          int          off;
          logic [31:0] wd;
          logic [31:0] t;
          logic [31:0] exp;
          logic [7:0]  b;
          logic        got;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          kind = $urandom_range(0, 4);
          w    = $urandom_range(128, 255);
          off  = $urandom_range(0, 3);
          wd   = $urandom;
          t    = shadow[w];
          b    = t[31-8*off -: 8];
          case (kind)
            0: exp = t;
            1: begin
              shadow[w] = wd;
              exp       = 32'h0;
            end
            2: exp = {{24{b[7]}}, b};
            3: exp = {24'h0, b};
            default: begin
              t[31-8*off -: 8] = wd[7:0];
              shadow[w]        = t;
              exp              = 32'h0;
            end
          endcase
          bus.d_addr   = 32'(w * 4 + off);
          bus.d_we     = (kind == 1) || (kind == 4);
          bus.d_word   = (kind <= 1);
          bus.d_signed = (kind == 2);
          bus.d_wdata  = wd;
          bus.d_req    = 1'b1;
          got          = 1'b0;
          for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.d_ack) begin
              got = 1'b1;
              break;
            end
          end
          checks++;
          if (!got) begin
            errors++;
            $display("FAIL rand_data_timeout n=%0d kind=%0d: got no d_ack required ack", n, kind);
          end else if (bus.d_rdata !== exp) begin
            errors++;
            $display("FAIL rand_data n=%0d kind=%0d addr=%h: got %h required %h",
                     n, kind, bus.d_addr, bus.d_rdata, exp);
          end
          bus.d_req = 1'b0;
        end
      end
    join
    repeat (4) @(negedge clk);
    auto_mode = 1'b0;
    for (int i = 128; i < 256; i++)
      if (tmem[i] !== shadow[i]) mism++;
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL rand_mem_image: got %0d differing words required 0", mism);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_fetch_single();
    test_byte_access();
    test_starvation();
    test_reset_mid();
    test_wait_limit();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
